// File: rtl/fir_avmm_host.sv
// Avalon-MM initiator feeding the FIR CSR slave from a sample stream.
// Per sample: shift the window, write it out, settle, read the result, return it.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clr               window clear, honoured only while idle
//   s_valid/s_ready   8-bit sample input stream (s_data)
//   m_valid/m_ready   18-bit result output stream (m_data)
//   busy              high whenever a sample is in flight
//   chipselect, write, read, address, writedata, readdata
//                     Avalon-MM initiator port to the FIR slave
module fir_avmm_host #(
    parameter int N_TAPS        = 8,
    parameter int SETTLE_CYCLES = 2,
    parameter int READ_LAT      = 1,
    parameter int RESULT_ADDR   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [17:0] m_data,
    output logic        busy,
    output logic        chipselect,
    output logic        write,
    output logic        read,
    output logic [3:0]  address,
    output logic [31:0] writedata,
    input  logic [31:0] readdata
);

    localparam int IDXW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam int MAXC = (SETTLE_CYCLES > READ_LAT) ? SETTLE_CYCLES : READ_LAT;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N_TAPS - 1);
    localparam logic [CW-1:0]   SET_LAST =
        CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [CW-1:0]   RD_LAST  = CW'(READ_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_SETTLE,
        S_READ,
        S_RWAIT,
        S_OUT
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [IDXW-1:0] idx;
    logic [CW-1:0]   cnt;
    logic [7:0]      win [N_TAPS];

    // Only the low 18 bits of the result register carry the filter output.
    logic unused_rd_hi;
    assign unused_rd_hi = ^readdata[31:18];

    assign s_ready = (state == S_IDLE) && !clr;
    assign m_valid = (state == S_OUT);
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            idx    <= '0;
            cnt    <= '0;
            m_data <= '0;
            for (int i = 0; i < N_TAPS; i++) win[i] <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                S_IDLE: begin
                    if (clr) begin
                        for (int i = 0; i < N_TAPS; i++) win[i] <= '0;
                    end else if (s_valid) begin
                        for (int i = N_TAPS - 1; i > 0; i--) win[i] <= win[i-1];
                        win[0] <= s_data;
                        idx    <= '0;
                    end
                end
                S_WRITE: begin
                    idx <= idx + 1'b1;
                    cnt <= '0;
                end
                S_SETTLE: cnt <= cnt + 1'b1;
                S_READ:   cnt <= '0;
                S_RWAIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == RD_LAST) m_data <= readdata[17:0];
                end
                default: ;
            endcase
        end
    end

    // Bus outputs decode straight from state so reset drops strobes at once.
    always_comb begin
        state_nx   = state;
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        address    = '0;
        writedata  = '0;
        unique case (state)
            S_IDLE: begin
                if (!clr && s_valid) state_nx = S_WRITE;
            end
            S_WRITE: begin
                chipselect = 1'b1;
                write      = 1'b1;
                address    = 4'(idx);
                writedata  = {24'b0, win[idx]};
                if (idx == IDX_LAST)
                    state_nx = (SETTLE_CYCLES == 0) ? S_READ : S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt == SET_LAST) state_nx = S_READ;
            end
            S_READ: begin
                chipselect = 1'b1;
                read       = 1'b1;
                address    = 4'(RESULT_ADDR);
                state_nx   = S_RWAIT;
            end
            S_RWAIT: begin
                if (cnt == RD_LAST) state_nx = S_OUT;
            end
            S_OUT: begin
                if (m_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fir_avmm_host.sv
// Bench for fir_avmm_host: default instance plus a SETTLE=0/READ_LAT=3 instance.
// Stimulus pushes expected writes/results; a negedge monitor pops and compares.
module tb_fir_avmm_host;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clr, s_valid, m_ready;
    logic [7:0]  s_data;

    logic        s_ready_a, m_valid_a, busy_a, cs_a, wr_a, rd_a;
    logic [17:0] m_data_a;
    logic [3:0]  addr_a;
    logic [31:0] wdata_a, rdata_a;

    logic        s_ready_b, m_valid_b, busy_b, cs_b, wr_b, rd_b;
    logic [17:0] m_data_b;
    logic [3:0]  addr_b;
    logic [31:0] wdata_b, rdata_b;

    fir_avmm_host u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data),
        .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a),
        .busy(busy_a), .chipselect(cs_a), .write(wr_a), .read(rd_a),
        .address(addr_a), .writedata(wdata_a), .readdata(rdata_a)
    );

    fir_avmm_host #(.SETTLE_CYCLES(0), .READ_LAT(3)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
        .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b),
        .busy(busy_b), .chipselect(cs_b), .write(wr_b), .read(rd_b),
        .address(addr_b), .writedata(wdata_b), .readdata(rdata_b)
    );

    // Slave models: result = sum of sample regs, valid only READ_LAT after read.
    logic       ovr = 1'b0;
    logic [7:0] regs_a [8] = '{default: 8'h0};
    logic [7:0] regs_b [8] = '{default: 8'h0};
    logic       pipe_a = 1'b0;
    logic [2:0] pipe_b = 3'b0;
    logic [31:0] res_a, res_b;

    always @(posedge clk) begin
        if (cs_a && wr_a) regs_a[addr_a[2:0]] <= wdata_a[7:0];
        if (cs_b && wr_b) regs_b[addr_b[2:0]] <= wdata_b[7:0];
        pipe_a <= rd_a;
        pipe_b <= {pipe_b[1:0], rd_b};
    end

    always_comb begin
        res_a = 32'h0;
        res_b = 32'h0;
        for (int i = 0; i < 8; i++) begin
            res_a = res_a + 32'(regs_a[i]);
            res_b = res_b + 32'(regs_b[i]);
        end
        if (ovr) begin
            res_a = 32'hFFFC_0ABC;
            res_b = 32'hFFFC_0ABC;
        end
        rdata_a = pipe_a    ? res_a : 32'h0001_2345;
        rdata_b = pipe_b[2] ? res_b : 32'h0001_2345;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc   = 0;

    logic [35:0] wq_a [$];
    logic [35:0] wq_b [$];
    logic [17:0] rq_a [$];
    logic [17:0] rq_b [$];
    logic [7:0]  mwin [8];
    logic        mv_pa = 1'b0;
    logic        mv_pb = 1'b0;
    logic        hold_on = 1'b0;
    logic [17:0] held = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            logic [35:0] ew;
            logic [17:0] er;
            if (s_valid && s_ready_a) acc = cyc;
            // instance a
            if (cs_a && wr_a) begin
                if (wq_a.size() == 0) chk("a_extra_write", 64'(1), 64'(0));
                else begin
                    ew = wq_a.pop_front();
                    chk("a_write", 64'({addr_a, wdata_a}), 64'(ew));
                end
            end
            if (cs_a && rd_a) begin
                chk("a_read_cycle", 64'(cyc - acc), 64'(11));
                chk("a_read_addr", 64'(addr_a), 64'(8));
            end
            if (cs_a) chk("a_one_strobe", 64'(wr_a ^ rd_a), 64'(1));
            else chk("a_idle_bus", 64'({wr_a, rd_a, addr_a, wdata_a}), 64'(0));
            if (busy_a) chk("a_sready_busy", 64'(s_ready_a), 64'(0));
            if (m_valid_a && !mv_pa) chk("a_latency", 64'(cyc - acc), 64'(13));
            if (m_valid_a && !m_ready) begin
                if (hold_on) chk("a_hold_data", 64'(m_data_a), 64'(held));
                else begin
                    held    = m_data_a;
                    hold_on = 1'b1;
                end
            end
            if (m_valid_a && m_ready) begin
                hold_on = 1'b0;
                if (rq_a.size() == 0) chk("a_extra_result", 64'(1), 64'(0));
                else begin
                    er = rq_a.pop_front();
                    chk("a_result", 64'(m_data_a), 64'(er));
                end
            end
            // instance b
            if (cs_b && wr_b) begin
                if (wq_b.size() == 0) chk("b_extra_write", 64'(1), 64'(0));
                else begin
                    ew = wq_b.pop_front();
                    chk("b_write", 64'({addr_b, wdata_b}), 64'(ew));
                end
            end
            if (cs_b && rd_b) chk("b_read_cycle", 64'(cyc - acc), 64'(9));
            if (m_valid_b && !mv_pb) chk("b_latency", 64'(cyc - acc), 64'(13));
            if (m_valid_b && m_ready) begin
                if (rq_b.size() == 0) chk("b_extra_result", 64'(1), 64'(0));
                else begin
                    er = rq_b.pop_front();
                    chk("b_result", 64'(m_data_b), 64'(er));
                end
            end
        end
        mv_pa = m_valid_a;
        mv_pb = m_valid_b;
    end

    task automatic wait_idle();
        int t = 0;
        while (!s_ready_a && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) chk("idle_timeout", 64'(1), 64'(0));
    endtask

    task automatic send(input logic [7:0] d);
        logic [17:0] s;
        wait_idle();
        for (int i = 7; i > 0; i--) mwin[i] = mwin[i-1];
        mwin[0] = d;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            s = s + 18'(mwin[i]);
            wq_a.push_back({4'(i), 24'b0, mwin[i]});
            wq_b.push_back({4'(i), 24'b0, mwin[i]});
        end
        if (ovr) s = 18'h00ABC;
        rq_a.push_back(s);
        rq_b.push_back(s);
        s_valid = 1'b1;
        s_data  = d;
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) mwin[i] = '0;
    endtask

    initial begin
        int t;
        rst_n = 1'b0; clr = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bus", 64'({cs_a, wr_a, rd_a, addr_a, wdata_a}), 64'(0));
        chk("rst_out", 64'({m_valid_a, busy_a, m_data_a}), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_sready", 64'(s_ready_a), 64'(1));

        // single sample into empty window
        send(8'd5);

        // clear, then ramp 1..9: last window 9..2 sums to 44
        wait_idle();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        clear_model();
        for (int k = 1; k <= 9; k++) send(8'(k));

        // back-pressure in OUT
        wait_idle();
        m_ready = 1'b0;
        send(8'd7);
        t = 0;
        while (!m_valid_a && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) chk("mvalid_timeout", 64'(1), 64'(0));
        repeat (20) @(posedge clk);
        #1;
        m_ready = 1'b1;

        // clr beats s_valid in IDLE
        wait_idle();
        clr = 1'b1; s_valid = 1'b1; s_data = 8'h55;
        #1;
        chk("clr_sready", 64'(s_ready_a), 64'(0));
        @(posedge clk); #1;
        clr = 1'b0; s_valid = 1'b0; s_data = '0;
        chk("clr_not_taken", 64'(busy_a), 64'(0));
        clear_model();
        send(8'd3);

        // async reset during WRITE idx 4
        send(8'h11);
        t = 0;
        while (!(cs_a && wr_a && addr_a == 4'd4) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) chk("write4_timeout", 64'(1), 64'(0));
        rst_n = 1'b0;
        #1;
        chk("rst_async_a", 64'({cs_a, wr_a, busy_a}), 64'(0));
        chk("rst_async_b", 64'({cs_b, wr_b, busy_b}), 64'(0));
        wq_a.delete(); wq_b.delete(); rq_a.delete(); rq_b.delete();
        hold_on = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'h22);

        // upper readdata bits ignored
        wait_idle();
        ovr = 1'b1;
        send(8'h01);
        wait_idle();
        ovr = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("drain_a", 64'(wq_a.size() + rq_a.size()), 64'(0));
        chk("drain_b", 64'(wq_b.size() + rq_b.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
